// File: rtl/wb_regfile_unit_if.sv
// Write-back bus between the WB control stage and the register-file unit:
// commit strobes, WB fields/data, external ports and the two decode read ports.
interface wb_regfile_unit_if #(
  parameter int DATA_W = 8
);
  logic              write_en;
  logic              sw1;
  logic              sw2;
  logic              sp_inc;
  logic              sp_dec;
  logic              ld_out;
  logic              HLT_en;
  logic [1:0]        ra_wb;
  logic [1:0]        rb_wb;
  logic [DATA_W-1:0] wb_data;
  logic [DATA_W-1:0] rb_val_wb;
  logic [DATA_W-1:0] in_port;
  logic              intr;
  logic [1:0]        rd_addr_a;
  logic [1:0]        rd_addr_b;
  logic [DATA_W-1:0] rd_data_a;
  logic [DATA_W-1:0] rd_data_b;
  logic [DATA_W-1:0] sp_out;
  logic [DATA_W-1:0] out_port;
  logic              halted;
  logic              stack_fault;

  modport master (
    output write_en, sw1, sw2, sp_inc, sp_dec, ld_out, HLT_en, ra_wb, rb_wb,
           wb_data, rb_val_wb, in_port, intr, rd_addr_a, rd_addr_b,
    input  rd_data_a, rd_data_b, sp_out, out_port, halted, stack_fault
  );

  modport slave (
    input  write_en, sw1, sw2, sp_inc, sp_dec, ld_out, HLT_en, ra_wb, rb_wb,
           wb_data, rb_val_wb, in_port, intr, rd_addr_a, rd_addr_b,
    output rd_data_a, rd_data_b, sp_out, out_port, halted, stack_fault
  );
endinterface

// File: rtl/wb_regfile_unit.sv
// Write-back stage: 4-entry register file (R3 = stack pointer), OUT port and halt FSM,
// with bypassed read ports. Define SP_BOUNDS_CHECK_EN to trap SP over/underflow.
module wb_regfile_unit #(
  parameter int                DATA_W    = 8,
  parameter logic [DATA_W-1:0] SP_RESET  = 8'hFF,
  parameter logic [DATA_W-1:0] OUT_RESET = 8'h00
) (
  input  logic                clk,
  input  logic                rst,
  wb_regfile_unit_if.slave    bus
);

  typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_e;

  state_e                       state_q, state_d;
  logic [3:0][DATA_W-1:0]       rf_q;
  logic [DATA_W-1:0]            out_q;

  logic                         run;
  logic                         we;
  logic [1:0]                   waddr;
  logic [DATA_W-1:0]            wdata;
  logic                         sp_req;
  logic                         sp_edge;
  logic                         sp_pend;
  logic [DATA_W-1:0]            sp_nxt;

  always_comb begin
    run     = (state_q == RUN);
    we      = run && bus.write_en;
    waddr   = bus.sw1 ? bus.rb_wb : bus.ra_wb;
    wdata   = bus.sw2 ? bus.in_port : bus.wb_data;
    // inc+dec together cancel out
    sp_req  = run && (bus.sp_inc ^ bus.sp_dec);
    sp_nxt  = bus.sp_inc ? rf_q[3] + DATA_W'(1) : rf_q[3] - DATA_W'(1);
`ifdef SP_BOUNDS_CHECK_EN
    sp_edge = (bus.sp_inc && (rf_q[3] == {DATA_W{1'b1}})) ||
              (bus.sp_dec && (rf_q[3] == {DATA_W{1'b0}}));
`else
    sp_edge = 1'b0;
`endif
    // an explicit write to R3 overrides (and suppresses) the SP update
    sp_pend = sp_req && !(we && (waddr == 2'd3)) && !sp_edge;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_q  <= {SP_RESET, {(3*DATA_W){1'b0}}};
      out_q <= OUT_RESET;
    end else begin
      if (we)         rf_q[waddr] <= wdata;
      if (sp_pend)    rf_q[3]     <= sp_nxt;
      if (run && bus.ld_out) out_q <= bus.rb_val_wb;
    end
  end

`ifdef SP_BOUNDS_CHECK_EN
  logic fault_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                            fault_q <= 1'b0;
    else if (sp_req && sp_edge && !(we && waddr == 2'd3)) fault_q <= 1'b1;
  end

  assign bus.stack_fault = fault_q;
`else
  assign bus.stack_fault = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  // intr seen together with HLT_en is left pending; it wakes us next cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (bus.HLT_en) state_d = HALTED;
      HALTED:  if (bus.intr)   state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  assign bus.rd_data_a = (we && waddr == bus.rd_addr_a)   ? wdata  :
                         (sp_pend && bus.rd_addr_a == 2'd3) ? sp_nxt :
                         rf_q[bus.rd_addr_a];
  assign bus.rd_data_b = (we && waddr == bus.rd_addr_b)   ? wdata  :
                         (sp_pend && bus.rd_addr_b == 2'd3) ? sp_nxt :
                         rf_q[bus.rd_addr_b];
  assign bus.sp_out    = rf_q[3];
  assign bus.out_port  = out_q;
  assign bus.halted    = (state_q == HALTED);

endmodule

// File: tb/tb_wb_regfile_unit.sv
// Directed bench for wb_regfile_unit: reset, write/bypass, SP, OUT, halt and SP wrap.
module tb_wb_regfile_unit;
  logic clk = 1'b0;
  logic rst;
  int   errs   = 0;
  int   checks = 0;

  wb_regfile_unit_if #(.DATA_W(8)) bus ();

  wb_regfile_unit #(.DATA_W(8), .SP_RESET(8'hFF), .OUT_RESET(8'h00)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.write_en = 0; bus.sw1 = 0; bus.sw2 = 0; bus.sp_inc = 0; bus.sp_dec = 0;
    bus.ld_out = 0; bus.HLT_en = 0; bus.intr = 0;
    bus.ra_wb = 0; bus.rb_wb = 0; bus.wb_data = 0; bus.rb_val_wb = 0; bus.in_port = 0;
  endtask

  task automatic do_reset();
    idle();
    bus.rd_addr_a = 0; bus.rd_addr_b = 0;
    rst = 1'b1;
    #12;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    logic [7:0] exp_r [4];
    exp_r = '{8'h00, 8'h00, 8'h00, 8'hFF};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      bus.rd_addr_a = 2'(i);
      bus.rd_addr_b = 2'(3 - i);
      #1;
      checks++;
      if (bus.rd_data_a !== exp_r[i]) begin
        errs++; $display("FAIL reset_rd_a[%0d] got=%h exp=%h", i, bus.rd_data_a, exp_r[i]);
      end
      checks++;
      if (bus.rd_data_b !== exp_r[3-i]) begin
        errs++; $display("FAIL reset_rd_b[%0d] got=%h exp=%h", 3-i, bus.rd_data_b, exp_r[3-i]);
      end
    end
    checks++;
    if (bus.sp_out !== 8'hFF) begin errs++; $display("FAIL reset_sp got=%h exp=ff", bus.sp_out); end
    checks++;
    if (bus.out_port !== 8'h00) begin errs++; $display("FAIL reset_out got=%h exp=00", bus.out_port); end
    checks++;
    if (bus.halted !== 1'b0) begin errs++; $display("FAIL reset_halted got=%b exp=0", bus.halted); end
    checks++;
    if (bus.stack_fault !== 1'b0) begin errs++; $display("FAIL reset_fault got=%b exp=0", bus.stack_fault); end
  endtask

  task automatic test_write_bypass();
    // in_port -> R2 via rb field; bypass visible before the edge
    bus.write_en = 1; bus.sw1 = 1; bus.sw2 = 1; bus.rb_wb = 2; bus.ra_wb = 0;
    bus.in_port = 8'h5A; bus.wb_data = 8'h33;
    bus.rd_addr_a = 2; bus.rd_addr_b = 0;
    #1;
    checks++;
    if (bus.rd_data_a !== 8'h5A) begin errs++; $display("FAIL bypass_a got=%h exp=5a", bus.rd_data_a); end
    checks++;
    if (bus.rd_data_b !== 8'h00) begin errs++; $display("FAIL bypass_b_other got=%h exp=00", bus.rd_data_b); end
    tick();
    idle();
    #1;
    checks++;
    if (bus.rd_data_a !== 8'h5A) begin errs++; $display("FAIL r2_commit got=%h exp=5a", bus.rd_data_a); end
    // wb_data -> R1 via ra field
    bus.write_en = 1; bus.ra_wb = 1; bus.rb_wb = 2; bus.wb_data = 8'h77; bus.in_port = 8'hEE;
    tick();
    idle();
    bus.rd_addr_b = 1;
    #1;
    checks++;
    if (bus.rd_data_b !== 8'h77) begin errs++; $display("FAIL r1_commit got=%h exp=77", bus.rd_data_b); end
    checks++;
    if (bus.rd_data_a !== 8'h5A) begin errs++; $display("FAIL r2_kept got=%h exp=5a", bus.rd_data_a); end
  endtask

  task automatic test_sp();
    bus.rd_addr_a = 3;
    bus.sp_dec = 1;
    #1;
    checks++;
    if (bus.rd_data_a !== 8'hFE) begin errs++; $display("FAIL sp_bypass got=%h exp=fe", bus.rd_data_a); end
    checks++;
    if (bus.sp_out !== 8'hFF) begin errs++; $display("FAIL sp_out_nobypass got=%h exp=ff", bus.sp_out); end
    repeat (3) tick();
    bus.sp_dec = 0;
    #1;
    checks++;
    if (bus.sp_out !== 8'hFC) begin errs++; $display("FAIL sp_dec3 got=%h exp=fc", bus.sp_out); end
    // explicit R3 write beats sp_inc
    bus.sp_inc = 1; bus.write_en = 1; bus.ra_wb = 3; bus.wb_data = 8'h40;
    #1;
    checks++;
    if (bus.rd_data_a !== 8'h40) begin errs++; $display("FAIL r3_wr_bypass got=%h exp=40", bus.rd_data_a); end
    tick();
    idle();
    #1;
    checks++;
    if (bus.sp_out !== 8'h40) begin errs++; $display("FAIL r3_wr_wins got=%h exp=40", bus.sp_out); end
    bus.sp_inc = 1; bus.sp_dec = 1;
    tick();
    idle();
    #1;
    checks++;
    if (bus.sp_out !== 8'h40) begin errs++; $display("FAIL sp_incdec got=%h exp=40", bus.sp_out); end
  endtask

  task automatic test_out();
    bus.ld_out = 1; bus.rb_val_wb = 8'hC3;
    #1;
    checks++;
    if (bus.out_port !== 8'h00) begin errs++; $display("FAIL out_pre got=%h exp=00", bus.out_port); end
    tick();
    idle();
    bus.rb_val_wb = 8'h12;
    #1;
    checks++;
    if (bus.out_port !== 8'hC3) begin errs++; $display("FAIL out_load got=%h exp=c3", bus.out_port); end
    tick();
    checks++;
    if (bus.out_port !== 8'hC3) begin errs++; $display("FAIL out_hold got=%h exp=c3", bus.out_port); end
  endtask

  task automatic test_halt();
    // write in the halting cycle still commits
    bus.HLT_en = 1; bus.write_en = 1; bus.ra_wb = 2; bus.wb_data = 8'h99;
    tick();
    idle();
    bus.rd_addr_a = 2; bus.rd_addr_b = 1;
    #1;
    checks++;
    if (bus.halted !== 1'b1) begin errs++; $display("FAIL halt_enter got=%b exp=1", bus.halted); end
    checks++;
    if (bus.rd_data_a !== 8'h99) begin errs++; $display("FAIL halt_cycle_wr got=%h exp=99", bus.rd_data_a); end
    bus.write_en = 1; bus.ra_wb = 1; bus.wb_data = 8'h11; bus.ld_out = 1; bus.rb_val_wb = 8'hAA;
    bus.sp_inc = 1;
    #1;
    checks++;
    if (bus.rd_data_b !== 8'h77) begin errs++; $display("FAIL halt_nobypass got=%h exp=77", bus.rd_data_b); end
    repeat (5) tick();
    checks++;
    if (bus.rd_data_b !== 8'h77) begin errs++; $display("FAIL halt_r1_hold got=%h exp=77", bus.rd_data_b); end
    checks++;
    if (bus.out_port !== 8'hC3) begin errs++; $display("FAIL halt_out_hold got=%h exp=c3", bus.out_port); end
    checks++;
    if (bus.sp_out !== 8'h40) begin errs++; $display("FAIL halt_sp_hold got=%h exp=40", bus.sp_out); end
    bus.ld_out = 0; bus.sp_inc = 0;
    bus.intr = 1;
    tick();
    bus.intr = 0;
    #1;
    checks++;
    if (bus.halted !== 1'b0) begin errs++; $display("FAIL wake got=%b exp=0", bus.halted); end
    checks++;
    if (bus.rd_data_b !== 8'h11) begin errs++; $display("FAIL wake_bypass got=%h exp=11", bus.rd_data_b); end
    tick();
    idle();
    #1;
    checks++;
    if (bus.rd_data_b !== 8'h11) begin errs++; $display("FAIL wake_commit got=%h exp=11", bus.rd_data_b); end
    // HLT_en with intr: halt first, wake the next cycle
    bus.HLT_en = 1; bus.intr = 1;
    tick();
    bus.HLT_en = 0;
    #1;
    checks++;
    if (bus.halted !== 1'b1) begin errs++; $display("FAIL hlt_intr_enter got=%b exp=1", bus.halted); end
    tick();
    bus.intr = 0;
    #1;
    checks++;
    if (bus.halted !== 1'b0) begin errs++; $display("FAIL hlt_intr_wake got=%b exp=0", bus.halted); end
  endtask

  task automatic test_sp_wrap();
    logic [7:0] exp_first;
    logic       exp_fault;
`ifdef SP_BOUNDS_CHECK_EN
    exp_first = 8'hFF; exp_fault = 1'b1;
`else
    exp_first = 8'h00; exp_fault = 1'b0;
`endif
    do_reset();
    bus.sp_inc = 1;
    tick();
    checks++;
    if (bus.sp_out !== exp_first) begin errs++; $display("FAIL wrap_first got=%h exp=%h", bus.sp_out, exp_first); end
    checks++;
    if (bus.stack_fault !== exp_fault) begin errs++; $display("FAIL fault_first got=%b exp=%b", bus.stack_fault, exp_fault); end
    repeat (255) tick();
    idle();
    #1;
    checks++;
    if (bus.sp_out !== 8'hFF) begin errs++; $display("FAIL wrap_256 got=%h exp=ff", bus.sp_out); end
    checks++;
    if (bus.stack_fault !== exp_fault) begin errs++; $display("FAIL fault_final got=%b exp=%b", bus.stack_fault, exp_fault); end
  endtask

  initial begin
    rst = 1'b0;
    idle();
    bus.rd_addr_a = 0; bus.rd_addr_b = 0;
    test_reset();
    test_write_bypass();
    test_sp();
    test_out();
    test_halt();
    test_sp_wrap();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached before summary");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/wb_regfile_unit.md
Name: wb_regfile_unit

Overview:
- Write-back consumer stage. Owns the 4-entry architectural register file, the stack pointer held in R3, the OUT port register and the halt state.
- Takes the decoded WB control strobes (write_en, sw1, sw2, sp_inc, sp_dec, ld_out, HLT_en) plus the WB-stage register fields and data, and commits them on the clock edge.
- Provides two combinational read ports with write-through bypass to the decode stage.

Parameters:
DATA_W, 8, datapath and register width
SP_RESET, 8'hFF, reset value of R3 (stack pointer)
OUT_RESET, 8'h00, reset value of out_port

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
write_en  in  1  RF write strobe from WB control
sw1  in  1  dest select: 0 = ra_wb, 1 = rb_wb
sw2  in  1  data select: 0 = wb_data, 1 = in_port
sp_inc  in  1  R3 <- R3+1
sp_dec  in  1  R3 <- R3-1
ld_out  in  1  load out_port from rb data
HLT_en  in  1  enter halt
ra_wb  in  2  WB-stage ra field
rb_wb  in  2  WB-stage rb field
wb_data  in  DATA_W  WB result (ALU/MEM)
rb_val_wb  in  DATA_W  R[rb] value carried to WB, for OUT
in_port  in  DATA_W  external input port
intr  in  1  interrupt request; wakes from halt
rd_addr_a  in  2  read port A address
rd_addr_b  in  2  read port B address
rd_data_a  out  DATA_W  read port A data
rd_data_b  out  DATA_W  read port B data
sp_out  out  DATA_W  current R3, for the memory stage
out_port  out  DATA_W  OUT port register
halted  out  1  1 while in HALTED state
stack_fault  out  1  sticky SP bound fault; 0 unless SP_BOUNDS_CHECK_EN

Behaviour:
Reset (rst=1, async):
- R0..R2 = 0, R3 = SP_RESET, out_port = OUT_RESET, halted = 0, stack_fault = 0, FSM = RUN.
- Reset asserted while HALTED returns the FSM to RUN immediately.

RF write:
- Condition: in RUN with write_en=1.
- Address: waddr = sw1 ? rb_wb : ra_wb.
- Data: wdata = sw2 ? in_port : wb_data.
- Committed at the edge; latency 1.

SP update (RUN only):
- sp_inc → R3+1; sp_dec → R3-1. Modulo 2^DATA_W: 0xFF+1 = 0x00, 0x00-1 = 0xFF.
- sp_inc and sp_dec both set: no change.
- Explicit RF write to R3 in the same cycle as an SP update: the RF write wins and the SP update is dropped.

OUT: ld_out=1 in RUN → out_port <= rb_val_wb. Otherwise out_port holds.

Read ports:
- rd_data_x = R[rd_addr_x], combinational.
- Bypass: if a RUN-state write targets rd_addr_x this cycle, rd_data_x = wdata.
- SP bypass: if R3 is read while an SP update is pending, rd_data_x = the updated SP value.
- sp_out = registered R3, with no bypass.

Halt FSM, states RUN and HALTED:
- RUN → HALTED when HLT_en=1. Writes, SP updates and ld_out in that same cycle still commit.
- HALTED: all write_en/sp/ld_out strobes are ignored; halted=1; registers hold.
- HALTED → RUN on intr=1. halted drops the following cycle.
- HLT_en and intr asserted together in RUN: enter HALTED. The intr is not consumed; it wakes the unit next cycle if still asserted.

Optional Feature:
Macro SP_BOUNDS_CHECK_EN.
- Defined:
  - sp_dec at R3=0x00, or sp_inc at R3=0xFF, does not modify R3 and sets stack_fault=1.
  - stack_fault is sticky until rst.
  - Explicit RF writes to R3 are never checked.
- Undefined:
  - SP wraps modulo 2^DATA_W.
  - stack_fault is constant 0 and no fault logic is built.

Test Plan:
- Reset, then read all regs → R0..R2=0x00, R3=0xFF, out_port=0x00, halted=0.
- write_en=1, sw1=1, sw2=1, rb_wb=2, in_port=0x5A, rd_addr_a=2 → rd_data_a=0x5A same cycle (bypass); R2=0x5A after the edge.
- sp_dec for 3 cycles from reset → R3=0xFC. Then sp_inc together with write_en to R3, wb_data=0x40 → R3=0x40.
- ld_out=1, rb_val_wb=0xC3 → out_port=0xC3 next cycle and held afterwards.
- HLT_en=1 → halted=1. Apply write_en (wb_data=0x11, ra_wb=1) for 5 cycles → R1 unchanged. Pulse intr → halted=0 next cycle, and the next write commits.
- From reset, apply 256 sp_inc:
  - Without SP_BOUNDS_CHECK_EN: R3 = 0xFF after all 256 (first inc wraps 0xFF→0x00), stack_fault=0.
  - With SP_BOUNDS_CHECK_EN: R3 stays 0xFF and stack_fault=1 after the first inc.
